sram22_64x32_req_ctrl: RTL
==========================

// Module: sram22_64x32_req_ctrl
// PURPOSE
//  Valid/ready front-end directly upstream of the 64x32 (m4, 8-bit write mask) SRAM22 macro.
//  Accepts read/write requests, drives the macro's single-port interface, and captures its
//  1-cycle read data into a small response FIFO. Response back-pressure never drops or
//  corrupts read data. Writes produce no response.
// PARAMETERS
//  DATA_WIDTH   32  word width; must equal macro width
//  ADDR_WIDTH   6   word address width (64 words)
//  WMASK_WIDTH  4   byte-lane mask width (DATA_WIDTH/8)
//  RSP_DEPTH    2   response FIFO entries; >=2 gives one read per cycle
// PORTS
//  clk         in   1            single clock; macro also samples on posedge clk
//  rst         in   1            asynchronous, active-high reset
//  req_valid   in   1            request present
//  req_ready   out  1            request accepted when req_valid & req_ready (fire)
//  req_we      in   1            1 = write, 0 = read
//  req_wmask   in   WMASK_WIDTH  byte enables, writes only
//  req_addr    in   ADDR_WIDTH   word address
//  req_wdata   in   DATA_WIDTH   write data
//  rsp_valid   out  1            read data available at FIFO head
//  rsp_ready   in   1            consumer takes head when rsp_valid & rsp_ready
//  rsp_rdata   out  DATA_WIDTH   FIFO head data
//  sram_we     out  1            to macro we
//  sram_wmask  out  WMASK_WIDTH  to macro wmask
//  sram_addr   out  ADDR_WIDTH   to macro addr
//  sram_din    out  DATA_WIDTH   to macro din
//  sram_dout   in   DATA_WIDTH   from macro dout; valid in the cycle after a read edge
// BEHAVIOUR
//  - Reset (async assert): occupancy, pointers, in-flight flag, FIFO storage cleared;
//    rsp_valid=0, rsp_rdata=0, req_ready=0, sram_we=0 while rst high.
//  - sram_addr/din/wmask = req_* combinationally; sram_we = fire & req_we & !rst.
//    Non-fire cycles perform a harmless macro read; its data is never captured.
//  - Credit rule (type-independent): req_ready = !rst & (occ + inflight - pop) < RSP_DEPTH,
//    pop = rsp_valid & rsp_ready. Combinational path rsp_ready -> req_ready is intentional.
//  - Read fire in cycle N sets inflight for N+1; in N+1 sram_dout is pushed into the FIFO
//    at the N+1 closing edge; rsp_valid rises in N+2. Read-to-response latency = 2 cycles.
//  - Write fire: macro updates mem at the edge; inflight not set; no response; the macro's
//    X dout in the next cycle is never captured.
//  - Push and pop in same cycle: occ unchanged, both pointers advance; pointers wrap at
//    RSP_DEPTH (non-power-of-two depths supported). Push into full FIFO is impossible by
//    the credit rule; assertion flags it.
//  - Read-after-write same address on consecutive cycles returns the new data (macro
//    commits at the write edge); no forwarding logic needed.
//  - rsp_rdata held stable while rsp_valid & !rsp_ready.
//  - Reset mid-operation discards in-flight and queued reads; no response after release.
// CONFIGURATION
//  SRAM_CTRL_STATS_EN defined: adds outputs stat_rd_cnt[15:0], stat_wr_cnt[15:0],
//   stat_stall_cnt[15:0] (cycles with req_valid & !req_ready); saturating at 16'hFFFF,
//   cleared by rst. Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  sram22_ctrl_pkg: DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH localparams, typedef sram_req_t
//   {we, wmask, addr, wdata}, typedef sram_word_t.
//  Sub-module sram22_rsp_fifo: parametric RSP_DEPTH FIFO with push/pop/occ/head outputs.
//  Top holds credit logic, inflight flag, macro drive, optional stats.
// TESTING (bench instantiates the real macro model)
//  1 Write addr 5 data 0xDEADBEEF wmask 4'hF, then read 5 -> rsp_valid 2 cycles after read
//    fire, rsp_rdata 0xDEADBEEF.
//  2 Write 0xFFFFFFFF to addr 9, then 0x00000000 wmask 4'b0101, read 9 -> 0xFF00FF00.
//  3 Back-to-back reads 0..15, rsp_ready=1 -> req_ready never drops, 16 responses in order.
//  4 rsp_ready=0, issue reads -> exactly RSP_DEPTH accepted then req_ready=0; raise
//    rsp_ready -> queued data drains unchanged, in order, req_ready same-cycle reasserts.
//  5 Assert rst with FIFO full and read in flight -> rsp_valid=0, req_ready=0 immediately;
//    after release no stale response; SRAM contents preserved.
//  6 With SRAM_CTRL_STATS_EN: 3 writes, 4 reads, 2 stalled cycles -> counters 4/3/2.

Source files
------------

// File: rtl/sram22_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram22_ctrl_pkg
// Shared widths and types for the valid/ready front-end of the 64x32 SRAM22
// macro (m4 column mux, 8-bit write-mask granularity).
//   DATA_WIDTH  : macro word width
//   ADDR_WIDTH  : word address width (64 words)
//   WMASK_WIDTH : one enable per byte lane
// ---------------------------------------------------------------------------
package sram22_ctrl_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 6;
    localparam int WMASK_WIDTH = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] sram_word_t;

    typedef struct packed {
        logic                   we;
        logic [WMASK_WIDTH-1:0] wmask;
        logic [ADDR_WIDTH-1:0]  addr;
        sram_word_t             wdata;
    } sram_req_t;

    // Pointer width that stays at least one bit for a single-entry FIFO.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sram22_rsp_fifo
// Response FIFO holding read data captured from the macro.  Depth need not
// be a power of two; pointers wrap explicitly at DEPTH.
//   clk, rst     : clock and asynchronous active-high reset (clears storage)
//   push_i       : write push_data_i at tail
//   pop_i        : consumer removes head (only meaningful when valid_o)
//   push_data_i  : data to enqueue
//   occ_o        : number of occupied entries
//   valid_o      : FIFO not empty
//   head_o       : data at head entry
// ---------------------------------------------------------------------------
module sram22_rsp_fifo
    import sram22_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_WIDTH-1:0]      push_data_i,
    output logic [$clog2(DEPTH+1)-1:0] occ_o,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      head_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    sram_word_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            occ_q <= occ_d;
        end
    end

    assign occ_o   = occ_q;
    assign valid_o = (occ_q != OW'(0));
    assign head_o  = mem_q[rd_ptr_q];

    sram22_rsp_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_i),
        .occ_i  (occ_q)
    );

endmodule

// File: rtl/sram22_rsp_fifo_chk.sv
// ---------------------------------------------------------------------------
// sram22_rsp_fifo_chk
// Property checker for the response FIFO: a push while every entry is
// occupied would overwrite unread data and must never happen.
//   clk, rst : clock and asynchronous active-high reset
//   push_i   : FIFO write strobe
//   occ_i    : current FIFO occupancy
// ---------------------------------------------------------------------------
module sram22_rsp_fifo_chk #(
    parameter int DEPTH = 2
) (
    input logic                         clk,
    input logic                         rst,
    input logic                         push_i,
    input logic [$clog2(DEPTH+1)-1:0]   occ_i
);

    // Flag any push that would land on a full FIFO.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && (occ_i == ($clog2(DEPTH+1))'(DEPTH))))
        else $error("response FIFO push while full");

endmodule

// File: rtl/sram22_64x32_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram22_64x32_req_ctrl
// Valid/ready request front-end for the 64x32 SRAM22 macro.  Requests drive
// the macro's single port directly; read data returning one cycle after the
// read edge is captured into a response FIFO.  Writes produce no response.
// Optional feature macro: SRAM_CTRL_STATS_EN adds saturating read, write and
// stall counters (stat_rd_cnt, stat_wr_cnt, stat_stall_cnt).
//   clk, rst                         : clock, async active-high reset
//   req_valid/ready/we/wmask/addr/wdata : request channel
//   rsp_valid/ready/rdata            : read response channel (FIFO head)
//   sram_we/wmask/addr/din, sram_dout : macro port
// ---------------------------------------------------------------------------
module sram22_64x32_req_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]            stat_rd_cnt,
    output logic [15:0]            stat_wr_cnt,
    output logic [15:0]            stat_stall_cnt
`endif
);

    localparam int OW = $clog2(RSP_DEPTH + 1);
    localparam int CW = OW + 1;

    sram_req_t     req_s;
    logic [OW-1:0] occ_s;
    logic [CW-1:0] credit_s;
    logic          fire_s;
    logic          pop_s;
    logic          inflight_q;
    logic          inflight_d;

    assign req_s = '{we: req_we, wmask: req_wmask, addr: req_addr, wdata: req_wdata};

    // Macro address/data/mask follow the request every cycle; idle cycles
    // therefore perform a harmless read whose data is never captured.
    assign sram_addr  = req_s.addr;
    assign sram_din   = req_s.wdata;
    assign sram_wmask = req_s.wmask;
    assign sram_we    = fire_s & req_s.we & ~rst;

    assign pop_s  = rsp_valid & rsp_ready;
    assign fire_s = req_valid & req_ready;

    // Credit: entries held plus the read in flight, less the entry leaving
    // this cycle, must leave room.  Depends on rsp_ready combinationally so
    // a full FIFO being drained still accepts a request in the same cycle.
    always_comb begin
        credit_s  = CW'(occ_s) + CW'(inflight_q) - CW'(pop_s);
        req_ready = ~rst & (credit_s < CW'(RSP_DEPTH));
    end

    // A read fired this cycle makes macro dout valid next cycle.
    always_comb begin
        if (fire_s && !req_s.we) begin
            inflight_d = 1'b1;
        end else begin
            inflight_d = 1'b0;
        end
    end

    // In-flight flag; cleared by reset so a pending read is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    sram22_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .pop_i       (pop_s),
        .push_data_i (sram_dout),
        .occ_o       (occ_s),
        .valid_o     (rsp_valid),
        .head_o      (rsp_rdata)
    );

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;
    logic [15:0] stall_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q    <= 16'd0;
            wr_cnt_q    <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q    <= sat_inc(rd_cnt_q, fire_s & ~req_s.we);
            wr_cnt_q    <= sat_inc(wr_cnt_q, fire_s & req_s.we);
            stall_cnt_q <= sat_inc(stall_cnt_q, req_valid & ~req_ready);
        end
    end

    assign stat_rd_cnt    = rd_cnt_q;
    assign stat_wr_cnt    = wr_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
